operand_bus_arbiter: RTL and testbench
======================================

// Module: operand_bus_arbiter
// PURPOSE
//   Shares one WIDTH-bit operand bus between two requesters using round-robin arbitration.
//   Each requester uses a valid/ready handshake.
//   The arbiter drives a 2:1 select and registers the winning beat in an output stage.
//   The output stage holds the beat until the consumer accepts it.
//   Sits between the two datapath sources and the shared downstream operand channel.
//   Keeps saturating per-source grant counters for debug and fairness checks.
// PARAMETERS
//   WIDTH    16   data width of the requester and output buses
//   CNT_W    8    width of each saturating grant counter
// PORTS
//   clk          in   1        single clock, rising edge
//   rst_n        in   1        synchronous reset, active-low
//   req0_valid   in   1        requester 0 has a beat
//   req0_data    in   WIDTH    requester 0 payload
//   req0_ready   out  1        requester 0 beat accepted this cycle
//   req1_valid   in   1        requester 1 has a beat
//   req1_data    in   WIDTH    requester 1 payload
//   req1_ready   out  1        requester 1 beat accepted this cycle
//   out_valid    out  1        output register holds a beat
//   out_data     out  WIDTH    registered payload
//   out_src      out  1        source of the held beat (0/1)
//   out_ready    in   1        consumer accepts the beat
//   clr_cnt      in   1        clear both grant counters
//   gnt_cnt0     out  CNT_W    grants issued to requester 0
//   gnt_cnt1     out  CNT_W    grants issued to requester 1
// BEHAVIOUR
//   Reset (rst_n=0 at a clk edge):
//     out_valid=0, out_data=0, out_src=0, gnt_cnt0/1=0, last_gnt=1 (src 0 wins the first tie).
//     Asserting reset mid-operation discards any held beat; no handshake completes that cycle.
//   State: EMPTY (out_valid=0) / FULL (out_valid=1).
//   load_en = !out_valid | out_ready. This is combinational, giving full throughput with no bubble.
//   Arbitration, evaluated only when load_en=1:
//     Both requesters valid -> grant goes to !last_gnt.
//     Exactly one valid -> grant goes to that one.
//     None valid -> no grant; state goes EMPTY if the held beat drained.
//   reqN_ready = load_en & grant[N]. At most one ready is high per cycle.
//   A ready is never high while its valid is low.
//   On a grant: out_data <= mux(sel=grant idx); out_src <= idx; out_valid <= 1; last_gnt <= idx.
//   When FULL and out_ready=0: out_data and out_src hold stable; both readies are 0.
//   Requesters may hold valid indefinitely.
//   Latency: one cycle from accepted request to out_valid.
//   A beat accepted at edge k is visible after edge k.
//   Grant counters increment on the accepted handshake and saturate at 2^CNT_W-1 (no wrap).
//   If clr_cnt and a grant occur in the same cycle, clear wins and the counter reads 0.
//   last_gnt updates only on a grant.
//   An idle cycle does not change the priority.
// STRUCTURE
//   Shared package: localparam SRC0=1'b0, SRC1=1'b1; state encoding ST_EMPTY/ST_FULL.
//   Sub-module rr_grant_2: inputs (valid[1:0], last_gnt, en) -> one-hot grant[1:0] plus idx.
//   rr_grant_2 is purely combinational.
//   Datapath: WIDTH-wide 2:1 mux selected by idx, feeding the output register.
//   The FSM, priority register and counters live in this module.
// TESTING
//   1 Reset: rst_n=0 with req0/1_valid=1 -> readies=0, out_valid=0, out_data=0, counters=0.
//     After release, the first tie grants src 0.
//   2 Single request: req0_valid=1, data=0x1234, out_ready=1 ->
//     next cycle out_valid=1, out_data=0x1234, out_src=0, gnt_cnt0=1.
//   3 Contention: both valid (0xA5A5 / 0x5A5A), out_ready=1 for 6 cycles ->
//     out_src sequence is 0,1,0,1,0,1 and gnt_cnt0=gnt_cnt1=3.
//   4 Backpressure: FULL with out_ready=0 for 4 cycles -> out_data stable and readies=0.
//     out_ready=1 -> the next beat loads in the same cycle with no bubble.
//   5 Saturation and clear: 300 grants to src 1 -> gnt_cnt1=255.
//     clr_cnt=1 together with a grant -> gnt_cnt1=0.
//   6 Reset while FULL with out_ready=0 -> out_valid=0 next cycle.
//     No ready is asserted and last_gnt resets to 1.

Source files
------------

// File: rtl/operand_bus_arbiter_pkg.sv
// Shared definitions for the two-source operand bus arbiter: source indices and
// output-stage state encoding.
package operand_bus_arbiter_pkg;

  localparam logic SRC0 = 1'b0;
  localparam logic SRC1 = 1'b1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

endpackage

// File: rtl/operand_bus_arbiter_rr_grant_2.sv
// Two-way round-robin grant: one-hot grant plus encoded winner index.
// Purely combinational; a tie goes to the source that did not win last.
module rr_grant_2
  import operand_bus_arbiter_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last_gnt,
  input  logic       en,
  output logic [1:0] grant,
  output logic       idx
);

  always_comb begin
    grant = 2'b00;
    idx   = SRC0;
    if (en) begin
      case (valid)
        2'b01: begin
          grant = 2'b01;
          idx   = SRC0;
        end
        2'b10: begin
          grant = 2'b10;
          idx   = SRC1;
        end
        2'b11: begin
          idx   = ~last_gnt;
          grant = (last_gnt == SRC1) ? 2'b01 : 2'b10;
        end
        default: begin
          grant = 2'b00;
          idx   = SRC0;
        end
      endcase
    end
  end

endmodule

// File: rtl/operand_bus_arbiter.sv
// Round-robin arbiter sharing one operand bus between two valid/ready sources,
// with a registered output stage and saturating per-source grant counters.
module operand_bus_arbiter
  import operand_bus_arbiter_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_src,
  input  logic             out_ready,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] gnt_cnt0,
  output logic [CNT_W-1:0] gnt_cnt1
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             src_q, src_d;
  logic             last_gnt_q, last_gnt_d;
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;

  logic             load_en;
  logic [1:0]       grant;
  logic             idx;
  logic [WIDTH-1:0] mux_data;

  assign load_en = (state_q == ST_EMPTY) | out_ready;

  // Gating with rst_n keeps any handshake from completing during reset.
  rr_grant_2 u_rr_grant_2 (
    .valid    ({req1_valid, req0_valid}),
    .last_gnt (last_gnt_q),
    .en       (load_en & rst_n),
    .grant    (grant),
    .idx      (idx)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign mux_data   = (idx == SRC1) ? req1_data : req0_data;

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    src_d      = src_q;
    last_gnt_d = last_gnt_q;
    if (load_en) begin
      if (|grant) begin
        state_d    = ST_FULL;
        data_d     = mux_data;
        src_d      = idx;
        last_gnt_d = idx;
      end else begin
        state_d    = ST_EMPTY;
      end
    end
  end

  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (clr_cnt) begin
      cnt0_d = '0;
      cnt1_d = '0;
    end else begin
      if (grant[0]) cnt0_d = sat_inc(cnt0_q);
      if (grant[1]) cnt1_d = sat_inc(cnt1_q);
    end
  end

  // Output stage / priority / counter registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      data_q     <= '0;
      src_q      <= SRC0;
      last_gnt_q <= SRC1;
      cnt0_q     <= '0;
      cnt1_q     <= '0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      src_q      <= src_d;
      last_gnt_q <= last_gnt_d;
      cnt0_q     <= cnt0_d;
      cnt1_q     <= cnt1_d;
    end
  end

  assign out_valid = (state_q == ST_FULL);
  assign out_data  = data_q;
  assign out_src   = src_q;
  assign gnt_cnt0  = cnt0_q;
  assign gnt_cnt1  = cnt1_q;

endmodule

// File: tb/tb_operand_bus_arbiter.sv
// Self-checking bench for operand_bus_arbiter: a transaction-level model is
// compared against the DUT every cycle, plus literal expectations per scenario.
module tb_operand_bus_arbiter;

  localparam int WIDTH = 16;
  localparam int CNT_W = 8;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req0_valid, req1_valid;
  logic [WIDTH-1:0] req0_data, req1_data;
  logic             req0_ready, req1_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_src;
  logic             out_ready;
  logic             clr_cnt;
  logic [CNT_W-1:0] gnt_cnt0, gnt_cnt1;

  int checks = 0;
  int errors = 0;

  // Model state: what the output stage holds and who was served last.
  bit          m_full;
  int          m_data;
  int          m_src;
  int          m_last;
  int          m_cnt[2];

  always #5 clk = ~clk;

  operand_bus_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_src    (out_src),
    .out_ready  (out_ready),
    .clr_cnt    (clr_cnt),
    .gnt_cnt0   (gnt_cnt0),
    .gnt_cnt1   (gnt_cnt1)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: compare DUT to the model mid-cycle, then advance the model.
  task automatic step();
    int  winner;
    bit  accept;
    int  exp_rdy[2];
    @(negedge clk);
    winner  = -1;
    accept  = rst_n && (!m_full || out_ready);
    if (accept) begin
      if (req0_valid && req1_valid) winner = (m_last == 0) ? 1 : 0;
      else if (req0_valid)          winner = 0;
      else if (req1_valid)          winner = 1;
    end
    exp_rdy[0] = (winner == 0) ? 1 : 0;
    exp_rdy[1] = (winner == 1) ? 1 : 0;
    chk("req0_ready", int'(req0_ready), exp_rdy[0]);
    chk("req1_ready", int'(req1_ready), exp_rdy[1]);
    chk("out_valid",  int'(out_valid),  int'(m_full));
    if (m_full) begin
      chk("out_data", int'(out_data), m_data);
      chk("out_src",  int'(out_src),  m_src);
    end
    chk("gnt_cnt0", int'(gnt_cnt0), m_cnt[0]);
    chk("gnt_cnt1", int'(gnt_cnt1), m_cnt[1]);
    @(posedge clk);
    if (!rst_n) begin
      m_full = 0; m_data = 0; m_src = 0; m_last = 1;
      m_cnt[0] = 0; m_cnt[1] = 0;
    end else begin
      if (accept) begin
        if (winner >= 0) begin
          m_full = 1;
          m_data = (winner == 0) ? int'(req0_data) : int'(req1_data);
          m_src  = winner;
          m_last = winner;
        end else begin
          m_full = 0;
        end
      end
      if (clr_cnt) begin
        m_cnt[0] = 0; m_cnt[1] = 0;
      end else if (winner >= 0) begin
        m_cnt[winner] = (m_cnt[winner] + 1 > CMAX) ? CMAX : m_cnt[winner] + 1;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  int src_seq[6];

  initial begin
    m_full = 0; m_data = 0; m_src = 0; m_last = 1;
    m_cnt[0] = 0; m_cnt[1] = 0;
    rst_n      = 1'b0;
    req0_valid = 1'b1; req0_data = 16'h1111;
    req1_valid = 1'b1; req1_data = 16'h2222;
    out_ready  = 1'b0;
    clr_cnt    = 1'b0;

    // Reset with both requesters valid: nothing is accepted.
    #1;
    chk("rst_rdy0", int'(req0_ready), 0);
    chk("rst_rdy1", int'(req1_ready), 0);
    step();
    step();
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data",  int'(out_data),  0);
    chk("rst_cnt0",      int'(gnt_cnt0),  0);
    chk("rst_cnt1",      int'(gnt_cnt1),  0);

    // First tie after reset goes to source 0.
    rst_n = 1'b1; out_ready = 1'b1;
    step();
    chk("tie_src",  int'(out_src),  0);
    chk("tie_data", int'(out_data), 16'h1111);
    req0_valid = 1'b0; req1_valid = 1'b0;
    step();
    chk("drain_valid", int'(out_valid), 0);

    // Single request.
    do_reset();
    req0_valid = 1'b1; req0_data = 16'h1234; out_ready = 1'b1;
    step();
    chk("single_valid", int'(out_valid), 1);
    chk("single_data",  int'(out_data),  16'h1234);
    chk("single_src",   int'(out_src),   0);
    chk("single_cnt0",  int'(gnt_cnt0),  1);
    req0_valid = 1'b0;
    step();

    // Contention: strict alternation starting with source 0.
    do_reset();
    req0_valid = 1'b1; req0_data = 16'hA5A5;
    req1_valid = 1'b1; req1_data = 16'h5A5A;
    out_ready  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      src_seq[i] = int'(out_src);
    end
    for (int i = 0; i < 6; i++) chk($sformatf("rr_src[%0d]", i), src_seq[i], i % 2);
    chk("rr_cnt0", int'(gnt_cnt0), 3);
    chk("rr_cnt1", int'(gnt_cnt1), 3);

    // Backpressure: held beat stays put, then next beat loads with no bubble.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("bp_data", int'(out_data), 16'h5A5A);
      chk("bp_rdy",  int'(req0_ready) + int'(req1_ready), 0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_rdy0", int'(req0_ready), 1);
    step();
    chk("bp_next_valid", int'(out_valid), 1);
    chk("bp_next_src",   int'(out_src),   0);
    chk("bp_next_data",  int'(out_data),  16'hA5A5);

    // Saturation of the source-1 counter, then clear racing a grant.
    do_reset();
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_data = 16'hBEEF;
    out_ready  = 1'b1;
    for (int i = 0; i < 300; i++) step();
    chk("sat_cnt1", int'(gnt_cnt1), 255);
    clr_cnt = 1'b1;
    step();
    chk("clr_cnt1", int'(gnt_cnt1), 0);
    clr_cnt = 1'b0;
    step();
    chk("post_clr_cnt1", int'(gnt_cnt1), 1);

    // Reset while FULL and stalled.
    req0_valid = 1'b1; req0_data = 16'h0F0F;
    out_ready  = 1'b0;
    step();
    chk("stall_valid", int'(out_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("rst_full_rdy", int'(req0_ready) + int'(req1_ready), 0);
    step();
    chk("rst_full_valid", int'(out_valid), 0);
    rst_n = 1'b1; out_ready = 1'b1;
    step();
    chk("rst_full_tie_src", int'(out_src), 0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
